// File: rtl/shift_pkg.sv
// Shared opcode encodings and a bit-level reference model for the shift pipeline.
package shift_pkg;

  // Encodings 3'b011 and 3'b111 alias ROR and ROL respectively.
  typedef enum logic [2:0] {
    OpSrl = 3'b000,
    OpSra = 3'b001,
    OpRor = 3'b010,
    OpSll = 3'b100,
    OpSla = 3'b101,
    OpRol = 3'b110
  } shift_op_e;

  typedef struct packed {
    logic [63:0] y;
    logic        zf;
    logic        vf;
  } shift_res_t;

  // Per-bit reference of the shifter for widths up to 64; not used by the datapath.
  function automatic shift_res_t shift_ref(input logic [63:0] x, input int unsigned s,
                                           input logic [2:0] op, input int unsigned w);
    shift_res_t r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      if (op[1]) begin
        if (op[2]) r.y[i] = x[(i + w - s) % w];
        else       r.y[i] = x[(i + s) % w];
      end else if (op[2]) begin
        r.y[i] = (i >= s) ? x[i - s] : 1'b0;
      end else begin
        if (i + s < w) r.y[i] = x[i + s];
        else           r.y[i] = op[0] ? x[w - 1] : 1'b0;
      end
    end
    if (op == OpSla) begin
      for (int unsigned j = 0; j < w; j++) begin
        if (j + 1 + s >= w && x[j] != x[w - 1]) r.vf = 1'b1;
      end
    end
    r.zf = (r.y == '0);
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Command and result handshake bundle for shift_pipe.
interface shift_pipe_if #(
  parameter int unsigned D_SIZE = 32,
  parameter int unsigned CNT_W  = 16
) ();
  localparam int unsigned S_W = $clog2(D_SIZE);

  logic              in_valid_in;
  logic              in_ready_out;
  logic [D_SIZE-1:0] x_in;
  logic [S_W-1:0]    s_in;
  logic [2:0]        op_in;
  logic              out_valid_out;
  logic              out_ready_in;
  logic [D_SIZE-1:0] y_out;
  logic              zf_out;
  logic              vf_out;
  logic              sticky_vf_out;
  logic              clr_sticky_in;
  logic [CNT_W-1:0]  ops_done_out;

  // Producer/consumer side.
  modport master (
    output in_valid_in, x_in, s_in, op_in, out_ready_in, clr_sticky_in,
    input  in_ready_out, out_valid_out, y_out, zf_out, vf_out, sticky_vf_out, ops_done_out
  );

  // Pipeline side.
  modport slave (
    input  in_valid_in, x_in, s_in, op_in, out_ready_in, clr_sticky_in,
    output in_ready_out, out_valid_out, y_out, zf_out, vf_out, sticky_vf_out, ops_done_out
  );
endinterface

// File: rtl/barrelshifter.sv
// Combinational barrel shifter: logical/arithmetic shifts and rotates with zero/overflow flags.
module barrelshifter
  import shift_pkg::*;
#(
  parameter int unsigned D_SIZE = 32
) (
  input  logic [D_SIZE-1:0]         x_i,
  input  logic [$clog2(D_SIZE)-1:0] s_i,
  input  logic [2:0]                op_i,
  output logic [D_SIZE-1:0]         y_o,
  output logic                      zf_o,
  output logic                      vf_o
);
  localparam int unsigned S_W = $clog2(D_SIZE);
  localparam logic [S_W:0] DW = (S_W + 1)'(D_SIZE);

  logic [S_W:0]        s_inv;
  logic [D_SIZE-1:0]   ror, rol, sla, res;

  // A shift by D_SIZE yields zero, so s=0 rotates come out as the identity.
  assign s_inv = DW - {1'b0, s_i};
  assign ror   = (x_i >> s_i) | (x_i << s_inv);
  assign rol   = (x_i << s_i) | (x_i >> s_inv);
  assign sla   = x_i << s_i;

  // Opcode decode; the rotate aliases fall into the default arm so no opcode yields X.
  always_comb begin
    res  = '0;
    vf_o = 1'b0;
    case (op_i)
      OpSrl:   res = x_i >> s_i;
      OpSra:   res = $unsigned($signed(x_i) >>> s_i);
      OpSll:   res = sla;
      OpSla: begin
        res  = sla;
        // Overflow when shifting back arithmetically does not recover the operand.
        vf_o = ($signed(sla) >>> s_i) != $signed(x_i);
      end
      default: res = op_i[2] ? rol : ror;
    endcase
    y_o  = res;
    zf_o = (res == '0);
  end

endmodule

// File: rtl/shift_pipe.sv
// Flow-controlled shift pipeline: command FIFO, shared barrel shifter, registered result
// stage, sticky overflow flag and completed-operation counter.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned D_SIZE     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic         clk_in,
  input logic         rst_n_in,
  shift_pipe_if.slave bus
);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned S_W = $clog2(D_SIZE);

  typedef struct packed {
    logic [D_SIZE-1:0] x;
    logic [S_W-1:0]    s;
    logic [2:0]        op;
  } cmd_t;

  cmd_t              mem [FIFO_DEPTH];
  cmd_t              head;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              in_ready_q, full_d, empty;
  logic              push, load, consume;
  logic [D_SIZE-1:0] sh_y;
  logic              sh_zf, sh_vf;
  logic              out_valid_q, zf_q, vf_q, sticky_q;
  logic [D_SIZE-1:0] y_q;
  logic [CNT_W-1:0]  cnt_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push    = bus.in_valid_in && in_ready_q;
  assign load    = !empty && (!out_valid_q || bus.out_ready_in);
  assign consume = out_valid_q && bus.out_ready_in;
  assign head    = mem[rd_ptr_q[AW-1:0]];

  // Next pointers and next-cycle fullness, so in_ready can be a plain register.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
  end

  // FIFO storage; entries need no reset since they are only read when non-empty.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= '{x: bus.x_in, s: bus.s_in, op: bus.op_in};
  end

  // FIFO pointers and registered ready.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= !full_d;
    end
  end

  barrelshifter #(
    .D_SIZE (D_SIZE)
  ) u_shifter (
    .x_i  (head.x),
    .s_i  (head.s),
    .op_i (head.op),
    .y_o  (sh_y),
    .zf_o (sh_zf),
    .vf_o (sh_vf)
  );

  // Result register: captured on load, held under backpressure, invalidated on a bare consume.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zf_q        <= 1'b0;
      vf_q        <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      y_q         <= sh_y;
      zf_q        <= sh_zf;
      vf_q        <= sh_vf;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  // Status: sticky overflow (set beats clear) and wrapping consume counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (consume && vf_q)        sticky_q <= 1'b1;
      else if (bus.clr_sticky_in) sticky_q <= 1'b0;
      if (consume)                cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready_out  = in_ready_q;
  assign bus.out_valid_out = out_valid_q;
  assign bus.y_out         = y_q;
  assign bus.zf_out        = zf_q;
  assign bus.vf_out        = vf_q;
  assign bus.sticky_vf_out = sticky_q;
  assign bus.ops_done_out  = cnt_q;

endmodule
